// File: rtl/sample_mem_arbiter_if.sv
// sample_mem_arbiter_if: voice request/ack bundle plus the shared sample-memory read port
interface sample_mem_arbiter_if #(
    parameter int NUM_CH = 4
) ();
    localparam int IW = $clog2(NUM_CH);
    logic                 s_enable;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH*24-1:0] ch_addr;
    logic [NUM_CH-1:0]    ch_ack;
    logic [15:0]          ch_data;
    logic [23:0]          s_addr;
    logic                 s_read;
    logic [15:0]          s_data;
    logic                 s_ready;
    logic [IW-1:0]        grant_id;
    logic                 busy;
    logic                 timeout_err;
    modport master (
        input  s_enable, ch_req, ch_addr, s_data, s_ready,
        output ch_ack, ch_data, s_addr, s_read, grant_id, busy, timeout_err
    );
    modport slave (
        output s_enable, ch_req, ch_addr, s_data, s_ready,
        input  ch_ack, ch_data, s_addr, s_read, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/sample_mem_arbiter.sv
// sample_mem_arbiter: round-robin sharing of one sample-memory read port, one read in flight
module sample_mem_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 255
) (
    input logic                 CLK,
    input logic                 RESET,
    sample_mem_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_CH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t            state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d, gnt_q, gnt_d, sel;
    logic [23:0]       addr_q, addr_d, pick;
    logic [15:0]       data_q, data_d, cnt_q, cnt_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic              terr_q, terr_d;
    // first requesting voice above the rr pointer wins, else the lowest at or below it
    always_comb begin
        sel = rr_q;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (bus.ch_req[i] && IW'(i) <= rr_q) sel = IW'(i);
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (bus.ch_req[i] && IW'(i) > rr_q) sel = IW'(i);
    end
    // address of the selected voice
    always_comb begin
        pick = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (IW'(i) == sel) pick = bus.ch_addr[i*24 +: 24];
    end
    // grant in IDLE, then wait for s_ready or abandon after TIMEOUT cycles of s_read
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = '0;
        ack_d   = '0;
        terr_d  = 1'b0;
        if (state_q == IDLE) begin
            if (bus.s_enable && |bus.ch_req) begin
                state_d = ISSUE;
                rr_d    = sel;
                gnt_d   = sel;
                addr_d  = pick;
            end
        end else if (bus.s_ready) begin
            state_d      = IDLE;
            data_d       = bus.s_data;
            ack_d[gnt_q] = 1'b1;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
            state_d      = IDLE;
            data_d       = '0;
            ack_d[gnt_q] = 1'b1;
            terr_d       = 1'b1;
        end else begin
            state_d = WAIT;
            cnt_d   = cnt_q + 16'd1;
        end
    end
    // state registers; reset abandons any read without acking it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            rr_q    <= IW'(NUM_CH - 1);
            gnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            terr_q  <= terr_d;
        end
    end
    assign bus.busy        = state_q != IDLE;
    assign bus.s_read      = state_q != IDLE;
    assign bus.s_addr      = addr_q;
    assign bus.grant_id    = gnt_q;
    assign bus.ch_ack      = ack_q;
    assign bus.ch_data     = data_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_sample_mem_arbiter.sv
// tb_sample_mem_arbiter: directed and random stimulus against a transaction-level model
module tb_sample_mem_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;
    logic CLK = 1'b0;
    logic RESET;
    int total = 0;
    int bad = 0;
    sample_mem_arbiter_if #(.NUM_CH(N)) bus ();
    sample_mem_arbiter #(.NUM_CH(N), .TIMEOUT(TO)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    always #5 CLK = ~CLK;
    bit          m_busy, m_terr;
    int          m_voice, m_age, m_rr;
    logic [23:0] m_addr;
    logic [15:0] m_data;
    logic [N-1:0] m_ack;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_step();
        int v;
        m_ack  = '0;
        m_terr = 1'b0;
        if (RESET) begin
            m_busy = 0; m_voice = 0; m_age = 0; m_rr = N - 1; m_addr = '0; m_data = '0;
        end else if (!m_busy) begin
            if (bus.s_enable && bus.ch_req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    v = (m_rr + k) % N;
                    if (bus.ch_req[v]) begin
                        m_voice = v;
                        break;
                    end
                end
                m_rr   = m_voice;
                m_addr = bus.ch_addr[m_voice*24 +: 24];
                m_busy = 1;
                m_age  = 1;
            end
        end else if (bus.s_ready) begin
            m_data = bus.s_data; m_ack[m_voice] = 1'b1; m_busy = 0;
        end else if (m_age == TO) begin
            m_data = '0; m_ack[m_voice] = 1'b1; m_terr = 1'b1; m_busy = 0;
        end else
            m_age++;
    endtask
    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        chk("ch_ack", 32'(bus.ch_ack), 32'(m_ack));
        chk("ch_data", 32'(bus.ch_data), 32'(m_data));
        chk("s_addr", 32'(bus.s_addr), 32'(m_addr));
        chk("s_read", 32'(bus.s_read), 32'(m_busy));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("grant_id", 32'(bus.grant_id), 32'(m_voice));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    endtask
    initial begin
        int pr;
        RESET = 1'b1;
        bus.s_enable = 1'b0;
        bus.ch_req = '0;
        bus.ch_addr = '0;
        bus.s_data = '0;
        bus.s_ready = 1'b0;
        cycle();
        cycle();
        RESET = 1'b0;
        bus.s_enable = 1'b1;
        bus.ch_req = 4'b0100;
        bus.ch_addr[2*24 +: 24] = 24'h012345;
        cycle();
        chk("single_addr", 32'(bus.s_addr), 32'h012345);
        chk("single_gid", 32'(bus.grant_id), 32'd2);
        cycle();
        bus.s_ready = 1'b1;
        bus.s_data = 16'hBEEF;
        cycle();
        chk("single_ack", 32'(bus.ch_ack), 32'b0100);
        chk("single_data", 32'(bus.ch_data), 32'hBEEF);
        bus.ch_req = '0;
        bus.s_ready = 1'b0;
        cycle();
        chk("single_ack_pulse", 32'(bus.ch_ack), 32'd0);
        bus.ch_req = 4'b0010;
        for (int i = 0; i < TO + 1; i++) cycle();
        chk("to_ack", 32'(bus.ch_ack), 32'b0010);
        chk("to_err", 32'(bus.timeout_err), 32'd1);
        chk("to_data", 32'(bus.ch_data), 32'd0);
        bus.ch_req = '0;
        cycle();
        pr = 100;
        for (int c = 0; c < 6000; c++) begin
            if (c % 250 == 0)
                case ($urandom_range(0, 3))
                    0: pr = 100;
                    1: pr = 50;
                    2: pr = 10;
                    default: pr = 0;
                endcase
            RESET = ($urandom_range(0, 299) == 0);
            bus.s_enable = ($urandom_range(0, 9) != 0);
            bus.ch_req = N'($urandom);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) bus.ch_addr[i*24 +: 24] = 24'($urandom);
            bus.s_ready = ($urandom_range(1, 100) <= pr);
            bus.s_data = 16'($urandom);
            cycle();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
